// File: rtl/watch_pkg.sv
// Shared widths, limits and BCD digit types for the time-of-day watch blocks.
package watch_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned MIN_UNITS_W   = BCD_DIGIT_W;
  localparam int unsigned MIN_TENS_W    = 3;
  localparam int unsigned HOUR_UNITS_W  = BCD_DIGIT_W;
  localparam int unsigned HOUR_TENS_W   = 2;

  localparam int unsigned BCD_UNITS_MAX = 9;
  localparam int unsigned MIN_TENS_MAX  = 5;
  localparam int unsigned HOUR_MAX_24   = 23;
  localparam int unsigned HOUR_MAX_12   = 12;

  typedef logic [MIN_UNITS_W-1:0]  min_units_t;
  typedef logic [MIN_TENS_W-1:0]   min_tens_t;
  typedef logic [HOUR_UNITS_W-1:0] hour_units_t;
  typedef logic [HOUR_TENS_W-1:0]  hour_tens_t;

  // Hours register payload: BCD digit pair plus the PM flag.
  typedef struct packed {
    hour_tens_t  tens;
    hour_units_t units;
    logic        pm;
  } hour_state_t;

endpackage : watch_pkg

// File: rtl/bcd_count.sv
// Two-digit BCD counter with enable, wrap at WRAP_TENS:WRAP_UNITS and a
// combinational carry-out that flags the wrapping increment.
module bcd_count
  import watch_pkg::*;
#(
  parameter int unsigned TENS_W     = MIN_TENS_W,
  parameter int unsigned WRAP_TENS  = MIN_TENS_MAX,
  parameter int unsigned WRAP_UNITS = BCD_UNITS_MAX
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   en_i,
  output logic [BCD_DIGIT_W-1:0] units_o,
  output logic [TENS_W-1:0]      tens_o,
  output logic                   carry_c
);

  logic [BCD_DIGIT_W-1:0] units_q, units_d;
  logic [TENS_W-1:0]      tens_q, tens_d;
  logic                   at_wrap_c;

  assign at_wrap_c = (units_q == BCD_DIGIT_W'(WRAP_UNITS)) &&
                     (tens_q  == TENS_W'(WRAP_TENS));
  assign carry_c   = en_i & at_wrap_c;

  // Next digit pair: wrap to 00, units 9 -> 0 with tens carry, else units +1.
  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    if (en_i) begin
      if (at_wrap_c) begin
        units_d = '0;
        tens_d  = '0;
      end else if (units_q == BCD_DIGIT_W'(BCD_UNITS_MAX)) begin
        units_d = '0;
        tens_d  = tens_q + TENS_W'(1);
      end else begin
        units_d = units_q + BCD_DIGIT_W'(1);
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      units_q <= '0;
      tens_q  <= '0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
    end
  end

  assign units_o = units_q;
  assign tens_o  = tens_q;

endmodule : bcd_count

// File: rtl/clock_hhmm.sv
// Time-of-day minutes/hours counter fed by the seconds divider's 1/60 Hz
// toggle. Each toggle edge is one minute; set inputs take priority over it.
// Optional build macro: H12_MODE_EN selects 12-hour display with PM flag;
// left undefined the clock counts 00..23 and pm_o stays 0.
module clock_hhmm
  import watch_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk60s_i,
  input  logic                    set_min_i,
  input  logic                    set_hour_i,
  output logic [MIN_UNITS_W-1:0]  min_units_o,
  output logic [MIN_TENS_W-1:0]   min_tens_o,
  output logic [HOUR_UNITS_W-1:0] hour_units_o,
  output logic [HOUR_TENS_W-1:0]  hour_tens_o,
  output logic                    pm_o,
  output logic                    day_tick_o
);

`ifdef H12_MODE_EN
  localparam hour_tens_t  TOP_TENS  = HOUR_TENS_W'(HOUR_MAX_12 / 10);
  localparam hour_units_t TOP_UNITS = HOUR_UNITS_W'(HOUR_MAX_12 % 10);
  localparam hour_tens_t  PRE_TENS  = HOUR_TENS_W'((HOUR_MAX_12 - 1) / 10);
  localparam hour_units_t PRE_UNITS = HOUR_UNITS_W'((HOUR_MAX_12 - 1) % 10);
  localparam hour_state_t HOUR_RST  = '{tens: TOP_TENS, units: TOP_UNITS, pm: 1'b0};
`else
  localparam hour_tens_t  TOP_TENS  = HOUR_TENS_W'(HOUR_MAX_24 / 10);
  localparam hour_units_t TOP_UNITS = HOUR_UNITS_W'(HOUR_MAX_24 % 10);
  localparam hour_state_t HOUR_RST  = '{tens: '0, units: '0, pm: 1'b0};
`endif

  logic        clk60s_q;
  logic        tick_c;
  logic        set_any_c;
  logic        run_c;
  logic        min_en_c;
  logic        min_carry_c;
  logic        hour_en_c;
  logic        day_roll_c;
  hour_state_t hour_q, hour_d;
  logic        day_tick_q;

  // Any divider edge is a minute; a set cycle swallows it.
  assign tick_c    = clk60s_i ^ clk60s_q;
  assign set_any_c = set_min_i | set_hour_i;
  assign run_c     = tick_c & ~set_any_c;
  assign min_en_c  = set_min_i | run_c;
  assign hour_en_c = set_hour_i | (run_c & min_carry_c);

  // Minutes 00..59; carry only honoured on the running (non-set) path.
  bcd_count #(
    .TENS_W     (MIN_TENS_W),
    .WRAP_TENS  (MIN_TENS_MAX),
    .WRAP_UNITS (BCD_UNITS_MAX)
  ) u_min (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .en_i    (min_en_c),
    .units_o (min_units_o),
    .tens_o  (min_tens_o),
    .carry_c (min_carry_c)
  );

  // Next hour value under the mode wrap rule, plus midnight detection.
  always_comb begin
    hour_d     = hour_q;
    day_roll_c = 1'b0;
    if (hour_en_c) begin
`ifdef H12_MODE_EN
      if (hour_q.tens == TOP_TENS && hour_q.units == TOP_UNITS) begin
        hour_d.tens  = '0;
        hour_d.units = HOUR_UNITS_W'(1);
      end else if (hour_q.tens == PRE_TENS && hour_q.units == PRE_UNITS) begin
        hour_d.tens  = TOP_TENS;
        hour_d.units = TOP_UNITS;
        hour_d.pm    = ~hour_q.pm;
        // Only a clock-driven 11 PM -> 12 AM starts a new day.
        day_roll_c   = run_c & hour_q.pm;
      end else
`else
      if (hour_q.tens == TOP_TENS && hour_q.units == TOP_UNITS) begin
        hour_d.tens  = '0;
        hour_d.units = '0;
        day_roll_c   = run_c;
      end else
`endif
      if (hour_q.units == HOUR_UNITS_W'(BCD_UNITS_MAX)) begin
        hour_d.units = '0;
        hour_d.tens  = hour_q.tens + HOUR_TENS_W'(1);
      end else begin
        hour_d.units = hour_q.units + HOUR_UNITS_W'(1);
      end
    end
  end

  // Edge-detect history, hour state and day pulse registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clk60s_q   <= 1'b0;
      hour_q     <= HOUR_RST;
      day_tick_q <= 1'b0;
    end else begin
      clk60s_q   <= clk60s_i;
      hour_q     <= hour_d;
      day_tick_q <= day_roll_c;
    end
  end

  assign hour_tens_o  = hour_q.tens;
  assign hour_units_o = hour_q.units;
  assign pm_o         = hour_q.pm;
  assign day_tick_o   = day_tick_q;

endmodule : clock_hhmm

// File: tb/tb_clock_hhmm.sv
// Self-checking bench for clock_hhmm against a minutes-of-day reference model.
module tb_clock_hhmm;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       clk60s_i;
  logic       set_min_i;
  logic       set_hour_i;
  logic [3:0] min_units_o;
  logic [2:0] min_tens_o;
  logic [3:0] hour_units_o;
  logic [1:0] hour_tens_o;
  logic       pm_o;
  logic       day_tick_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integer hour (0..23) and minute (0..59).
  int mdl_h;
  int mdl_m;
  bit mdl_day;
  bit mdl_prev;
  bit cur_c;

  clock_hhmm dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clk60s_i     (clk60s_i),
    .set_min_i    (set_min_i),
    .set_hour_i   (set_hour_i),
    .min_units_o  (min_units_o),
    .min_tens_o   (min_tens_o),
    .hour_units_o (hour_units_o),
    .hour_tens_o  (hour_tens_o),
    .pm_o         (pm_o),
    .day_tick_o   (day_tick_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    mdl_h    = 0;
    mdl_m    = 0;
    mdl_day  = 1'b0;
    mdl_prev = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit sm, input bit sh);
    bit tick;
    tick     = c ^ mdl_prev;
    mdl_prev = c;
    mdl_day  = 1'b0;
    if (sm || sh) begin
      if (sm) mdl_m = (mdl_m + 1) % 60;
      if (sh) mdl_h = (mdl_h + 1) % 24;
    end else if (tick) begin
      mdl_m = mdl_m + 1;
      if (mdl_m == 60) begin
        mdl_m   = 0;
        mdl_h   = (mdl_h + 1) % 24;
        mdl_day = (mdl_h == 0);
      end
    end
  endtask

  // Expected display {hh tens, hh units, mm tens, mm units, pm, day}.
  function automatic logic [14:0] exp_vec();
    int hd;
    bit pm;
`ifdef H12_MODE_EN
    hd = (mdl_h % 12 == 0) ? 12 : mdl_h % 12;
    pm = (mdl_h >= 12);
`else
    hd = mdl_h;
    pm = 1'b0;
`endif
    return {2'(hd / 10), 4'(hd % 10), 3'(mdl_m / 10), 4'(mdl_m % 10), pm, mdl_day};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {hour_tens_o, hour_units_o, min_tens_o, min_units_o, pm_o, day_tick_o};
  endfunction

  // One clk_i cycle: drive, let the edge pass, advance model, settle.
  task automatic cycle(input bit c, input bit sm, input bit sh);
    clk60s_i   = c;
    set_min_i  = sm;
    set_hour_i = sh;
    cur_c      = c;
    @(posedge clk_i);
    model_step(c, sm, sh);
    #1;
  endtask

  // Walk the time to th:tm using the set inputs only (no divider edges).
  task automatic preload(input int th, input int tm);
    for (int i = 0; i < 64 && (mdl_h != th || mdl_m != tm); i++)
      cycle(cur_c, mdl_m != tm, mdl_h != th);
  endtask

  task automatic test_reset();
    rstn_i     = 1'b0;
    clk60s_i   = 1'b0;
    set_min_i  = 1'b0;
    set_hour_i = 1'b0;
    cur_c      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset: got %h want %h", dut_vec(), exp_vec());
    end
    rstn_i = 1'b1;
  endtask

  task automatic test_tick_edges();
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL tick_rise: got %h want %h", dut_vec(), exp_vec());
    end
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL tick_hold: got %h want %h", dut_vec(), exp_vec());
    end
    cycle(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({min_tens_o, min_units_o} !== {3'd0, 4'd2} || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL tick_fall: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_rollover();
    preload(23, 59);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL preload_2359: got %h want %h", dut_vec(), exp_vec());
    end
    cycle(~cur_c, 1'b0, 1'b0);
    n_cmp++;
    if (day_tick_o !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL rollover: got %h want %h", dut_vec(), exp_vec());
    end
    cycle(cur_c, 1'b0, 1'b0);
    n_cmp++;
    if (day_tick_o !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL day_clear: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_set_min_61();
    preload(10, 0);
    for (int i = 0; i < 61; i++) begin
      cycle(cur_c, 1'b1, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL set_min_hold[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({hour_tens_o, hour_units_o, min_tens_o, min_units_o, day_tick_o} !==
        {2'd1, 4'd0, 3'd0, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL set_min_61_final: got %h want 10:01", dut_vec());
    end
  endtask

  task automatic test_set_hour_tick();
    preload(5, 20);
    cycle(~cur_c, 1'b0, 1'b1);
    n_cmp++;
    if ({hour_tens_o, hour_units_o, min_tens_o, min_units_o} !==
        {2'd0, 4'd6, 3'd2, 4'd0} || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL set_hour_tick: got %h want %h", dut_vec(), exp_vec());
    end
    cycle(cur_c, 1'b0, 1'b0);
    n_cmp++;
    if ({min_tens_o, min_units_o} !== {3'd2, 4'd0} || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL tick_lost: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_midcount();
    preload(14, 37);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL preload_1437: got %h want %h", dut_vec(), exp_vec());
    end
    #2;
    rstn_i     = 1'b0;
    clk60s_i   = 1'b0;
    set_min_i  = 1'b0;
    set_hour_i = 1'b0;
    cur_c      = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", dut_vec(), exp_vec());
    end
    @(posedge clk_i);
    #1;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_hold: got %h want %h", dut_vec(), exp_vec());
    end
    rstn_i = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({min_tens_o, min_units_o} !== {3'd0, 4'd1} || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL post_reset_tick: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit c;
    bit sm;
    bit sh;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50) preload(23, 57 + int'($urandom_range(0, 2)));
      c  = ($urandom_range(0, 1) == 1) ? ~cur_c : cur_c;
      sm = ($urandom_range(0, 7) == 0);
      sh = ($urandom_range(0, 7) == 0);
      cycle(c, sm, sh);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

`ifdef H12_MODE_EN
  task automatic test_h12();
    preload(11, 59);
    cycle(~cur_c, 1'b0, 1'b0);
    n_cmp++;
    if ({hour_tens_o, hour_units_o, min_tens_o, min_units_o, pm_o, day_tick_o} !==
        {2'd1, 4'd2, 3'd0, 4'd0, 1'b1, 1'b0} || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL h12_noon: got %h want %h", dut_vec(), exp_vec());
    end
    preload(23, 59);
    cycle(~cur_c, 1'b0, 1'b0);
    n_cmp++;
    if ({hour_tens_o, hour_units_o, min_tens_o, min_units_o, pm_o, day_tick_o} !==
        {2'd1, 4'd2, 3'd0, 4'd0, 1'b0, 1'b1} || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL h12_midnight: got %h want %h", dut_vec(), exp_vec());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tick_edges();
    test_rollover();
    test_set_min_61();
    test_set_hour_tick();
    test_reset_midcount();
    test_random();
`ifdef H12_MODE_EN
    test_h12();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_clock_hhmm
